div32_seq: RTL



---
 rtl/cpu_pkg.sv | 18 +
 rtl/div_step.sv | 31 +++
 rtl/div32_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types used by the EXE-stage divider.
//   DIV_WIDTH   : operand/result width of the iterative divider
//   DIV_CNT_W   : width of the divider step counter
//   div_state_e : divider FSM state encoding
//   DIV_ZERO_Q  : quotient forced on a divide by zero
package cpu_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 5;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage : cpu_pkg

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   rem_i     : partial remainder before the step (always < divisor)
//   bit_i     : next dividend bit shifted into the remainder
//   divisor_i : divisor magnitude
//   rem_c     : partial remainder after the step
//   q_bit_c   : quotient bit produced by the step
module div_step
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_c,
  output logic             q_bit_c
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // shifted < 2*divisor, so the WIDTH+1-bit difference never overflows and
  // its MSB is a true sign bit.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_bit_c = ~diff[WIDTH];
    rem_c   = q_bit_c ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule : div_step

// File: rtl/div32_seq.sv
// Iterative restoring divider, one quotient bit per clock, signed/unsigned.
//   clk, clrn   : clock (rising edge), asynchronous active-low reset
//   start       : request strobe, sampled only while busy=0
//   sign        : 1 = two's complement division, sampled with start
//   dividend    : numerator, sampled with start
//   divisor     : denominator, sampled with start
//   q, r        : registered quotient / remainder, updated on completion
//   busy        : operation in progress
//   ready       : one-cycle pulse when q/r are updated
//   div_by_zero : divisor was zero for the last completed operation
module div32_seq
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             ready,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // dvd_q doubles as the quotient shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_c     (step_rem),
    .q_bit_c   (step_qbit)
  );

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    raw_d      = raw_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    dbz_pend_d = dbz_pend_q;
    q_d        = q_q;
    r_d        = r_q;
    busy_d     = busy_q;
    ready_d    = 1'b0;
    dbz_d      = dbz_q;

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          dvd_d      = (sign && dividend[WIDTH-1]) ? neg(dividend) : dividend;
          dvs_d      = (sign && divisor[WIDTH-1])  ? neg(divisor)  : divisor;
          raw_d      = dividend;
          qneg_d     = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d     = sign & dividend[WIDTH-1];
          dbz_pend_d = (divisor == '0);
          rem_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = DIV_RUN;
        end
      end

      DIV_RUN: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DIV_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          dbz_d   = dbz_pend_q;
          if (dbz_pend_q) begin
            q_d = WIDTH'(DIV_ZERO_Q);
            r_d = raw_q;
          end else begin
            q_d = qneg_q ? neg(dvd_d) : dvd_d;
            r_d = rneg_q ? neg(step_rem) : step_rem;
          end
        end
      end

      default: state_d = DIV_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      raw_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dbz_pend_q <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      raw_q      <= raw_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dbz_pend_q <= dbz_pend_d;
      q_q        <= q_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      dbz_q      <= dbz_d;
    end
  end

  assign q           = q_q;
  assign r           = r_q;
  assign busy        = busy_q;
  assign ready       = ready_q;
  assign div_by_zero = dbz_q;

endmodule : div32_seq
